// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: snoops processor stores, queues bytes in a small FIFO, sends 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 16,
   parameter logic [31:0] TX_ADDR      = 32'h0000_0080,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        overrun
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] DEPTH     = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          hit_data, hit_clear, push, drop, pop, empty;
   logic [7:0]    head;
   logic          unused_upper;

   state_t        state, state_next;
   logic [15:0]   baud, baud_next;
   logic [2:0]    bitidx, bitidx_next;
   logic [7:0]    shift, shift_next;
   logic          tx_next;
`ifdef UART_TX_PARITY_EN
   logic          par;
`endif

   assign hit_data     = memwrite && (dataadr == TX_ADDR);
   assign hit_clear    = memwrite && (dataadr == TX_ADDR + 32'd4);
   assign empty        = (count == '0);
   assign fifo_full    = (count == DEPTH);
   assign busy         = (state != IDLE) || !empty;
   assign head         = fifo_mem[rd_ptr];
   assign unused_upper = ^writedata[31:8];

   // A store into a full FIFO still lands if the transmitter frees a slot on the same edge
   assign push = hit_data && (!fifo_full || pop);
   assign drop = hit_data && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= writedata[7:0];
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + (AW + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW + 1)'(1);
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (hit_clear) begin
            overrun <= 1'b0;
         end
      end
   end

   always_comb begin
      state_next  = state;
      baud_next   = baud;
      bitidx_next = bitidx;
      shift_next  = shift;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = head;
               baud_next  = '0;
               state_next = START;
            end
         end
         START: begin
            if (baud == BAUD_LAST) begin
               baud_next   = '0;
               bitidx_next = '0;
               state_next  = DATA;
            end else begin
               baud_next = baud + 16'd1;
            end
         end
         DATA: begin
            if (baud == BAUD_LAST) begin
               baud_next = '0;
               if (bitidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bitidx_next = bitidx + 3'd1;
                  shift_next  = {1'b0, shift[7:1]};
               end
            end else begin
               baud_next = baud + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud == BAUD_LAST) begin
               baud_next  = '0;
               state_next = STOP;
            end else begin
               baud_next = baud + 16'd1;
            end
         end
`endif
         STOP: begin
            // Chain straight into the next start bit so queued bytes go out with no idle gap
            if (baud == BAUD_LAST) begin
               baud_next = '0;
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = head;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase

      // The line level is decided from next-state values so the pin itself can be a flop
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = par;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         baud   <= '0;
         bitidx <= '0;
         shift  <= '0;
         tx     <= 1'b1;
      end else begin
         state  <= state_next;
         baud   <= baud_next;
         bitidx <= bitidx_next;
         shift  <= shift_next;
         tx     <= tx_next;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         par <= 1'b0;
      end else if (pop) begin
         par <= ^head;
      end
   end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a serial monitor decodes tx and compares.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
   localparam int          C     = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] ADDR  = 32'h80;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11 * C;
`else
   localparam int FRAME = 10 * C;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = '0;
   logic [31:0] writedata = '0;
   logic        tx, busy, fifo_full, overrun;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          store_cyc = 0;
   logic [7:0]  expq[$];
   int          starts[$];

   mmio_uart_tx #(.CLKS_PER_BIT(C), .TX_ADDR(ADDR), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .memwrite(memwrite),
      .dataadr(dataadr),
      .writedata(writedata),
      .tx(tx),
      .busy(busy),
      .fifo_full(fifo_full),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drives one bus cycle; bytes that should reach the line are queued for the monitor
   task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] data, input bit dropped);
      memwrite  = we;
      dataadr   = addr;
      writedata = data;
      if (we && addr == ADDR && !dropped) expq.push_back(data[7:0]);
      @(negedge clk);
      store_cyc = cyc;
   endtask

   task automatic idle(input int n);
      memwrite = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic waitDrain(input string name);
      bit ok;
      ok = 1'b0;
      memwrite = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (expq.size() == 0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({name, "_drain"}, 32'(ok), 32'd1);
   endtask

   task automatic waitCycles(input int n, output bit aborted);
      aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (reset) begin
            aborted = 1'b1;
            return;
         end
      end
   endtask

   // Serial receiver: samples each bit in its centre and scores the decoded frame
   initial begin : monitor
      logic [7:0] got;
      logic [7:0] expb;
      logic       startb, stopb, parb;
      bit         ab;
      int         st;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && tx === 1'b0) begin
            st = cyc;
            got = '0;
            parb = 1'b0;
            stopb = 1'b0;
            waitCycles(C / 2, ab);
            startb = tx;
            for (int k = 0; k < 8 && !ab; k++) begin
               waitCycles(C, ab);
               got[k] = tx;
            end
`ifdef UART_TX_PARITY_EN
            if (!ab) begin
               waitCycles(C, ab);
               parb = tx;
            end
`endif
            if (!ab) begin
               waitCycles(C, ab);
               stopb = tx;
            end
            if (!ab) begin
               starts.push_back(st);
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_frame: got byte %02h expected no frame", got);
               end else begin
                  expb = expq.pop_front();
                  checkOutput("frame_byte", 32'(got), 32'(expb));
                  checkOutput("start_bit", 32'(startb), 32'd0);
                  checkOutput("stop_bit", 32'(stopb), 32'd1);
`ifdef UART_TX_PARITY_EN
                  checkOutput("parity_bit", 32'(parb), 32'(^expb));
`endif
               end
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stim
      int         n;
      int         len;
      int         lows;
      logic [31:0] d;

      // A store held during reset must not be captured
      reset = 1'b1;
      memwrite = 1'b1;
      dataadr = ADDR;
      writedata = 32'h0000_00AA;
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_fifo_full", 32'(fifo_full), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      idle(FRAME);
      checkOutput("store_in_reset_ignored", 32'(busy), 32'd0);

      // Single frame: latency and busy window
      starts.delete();
      applyStimulus(1'b1, ADDR, 32'hFFFF_FF55, 1'b0);
      n = store_cyc;
      memwrite = 1'b0;
      while (cyc < n + FRAME) @(negedge clk);
      checkOutput("busy_last_stop_cycle", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("busy_after_frame", 32'(busy), 32'd0);
      checkOutput("single_frame_count", 32'(starts.size()), 32'd1);
      if (starts.size() > 0) checkOutput("start_latency", 32'(starts[0]), 32'(n + 1));

      // Overflow burst: five fit, the sixth is dropped
      starts.delete();
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, ADDR, 32'(i), i == 6);
         if (i == 5) checkOutput("fifo_full_after_5", 32'(fifo_full), 32'd1);
      end
      checkOutput("overrun_set", 32'(overrun), 32'd1);
      applyStimulus(1'b0, ADDR, 32'h11, 1'b0);
      checkOutput("overrun_kept_no_write", 32'(overrun), 32'd1);
      applyStimulus(1'b1, ADDR + 32'd8, 32'h22, 1'b0);
      checkOutput("overrun_kept_other_addr", 32'(overrun), 32'd1);
      applyStimulus(1'b1, ADDR + 32'd4, 32'h33, 1'b0);
      checkOutput("overrun_cleared", 32'(overrun), 32'd0);
      waitDrain("burst");
      checkOutput("burst_frame_count", 32'(starts.size()), 32'd5);
      for (int i = 1; i < starts.size(); i++)
         checkOutput("back_to_back_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));

      // Parity-sensitive values
      applyStimulus(1'b1, ADDR, 32'h0000_0007, 1'b0);
      applyStimulus(1'b1, ADDR, 32'hABCD_0003, 1'b0);
      waitDrain("parity_pair");

      // Random bursts with non-matching stores mixed in
      for (int b = 0; b < 16; b++) begin
         len = int'($urandom_range(1, DEPTH));
         for (int j = 0; j < len; j++) begin
            d = $urandom;
            case ($urandom_range(0, 5))
               0: applyStimulus(1'b0, ADDR, $urandom, 1'b0);
               1: applyStimulus(1'b1, ADDR - 32'd4, $urandom, 1'b0);
               default: ;
            endcase
            applyStimulus(1'b1, ADDR, d, 1'b0);
            idle(int'($urandom_range(0, 3)));
         end
         waitDrain("random_burst");
      end
      checkOutput("no_overrun_random", 32'(overrun), 32'd0);

      // Reset during data bit 3 with two bytes still queued
      applyStimulus(1'b1, ADDR, 32'h0000_00C3, 1'b0);
      n = store_cyc;
      applyStimulus(1'b1, ADDR, 32'h0000_005A, 1'b0);
      applyStimulus(1'b1, ADDR, 32'h0000_0096, 1'b0);
      memwrite = 1'b0;
      while (cyc < n + 1 + 4 * C + 1) @(negedge clk);
      reset = 1'b1;
      expq.delete();
      @(negedge clk);
      checkOutput("midframe_reset_tx", 32'(tx), 32'd1);
      checkOutput("midframe_reset_busy", 32'(busy), 32'd0);
      checkOutput("midframe_reset_fifo_full", 32'(fifo_full), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      checkOutput("no_frames_after_reset", 32'(lows), 32'd0);
      checkOutput("idle_after_reset", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter: TX_ADDR, default 32'h0000_0080, store address of the transmit data register.
REQ-003 Parameter: FIFO_DEPTH, default 4, transmit FIFO entries (power of 2, 2..16).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: memwrite  input  1  processor store strobe, same signal that drives the data memory write enable.
REQ-007 Port: dataadr  input  32  processor ALU/memory address.
REQ-008 Port: writedata  input  32  processor store data.
REQ-009 Port: tx  output  1  serial line, registered, idle high.
REQ-010 Port: busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 Port: fifo_full  output  1  FIFO occupancy equals FIFO_DEPTH.
REQ-012 Port: overrun  output  1  sticky flag, byte dropped because FIFO was full.

Function
REQ-013 The block SHALL snoop stores only; it drives no processor input and does not block the data memory write.
REQ-014 A store hits the data register when memwrite=1 and dataadr==TX_ADDR; the block SHALL enqueue writedata[7:0] at that edge; writedata[31:8] ignored.
REQ-015 A store with memwrite=1 and dataadr==TX_ADDR+4 SHALL clear overrun at that edge; writedata ignored.
REQ-016 Enqueue when full SHALL be accepted only if the FSM pops in the same cycle; otherwise byte dropped, FIFO unchanged, overrun set at that edge.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 IDLE: tx=1; if FIFO non-empty, pop head into shift register, clear baud counter, go START at that edge.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, then PARITY or STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; then, if FIFO non-empty, pop and go START directly (back-to-back, no idle gap), else IDLE.
REQ-023 Latency: store at edge N into empty FIFO with FSM IDLE SHALL give tx falling after edge N+1.
REQ-024 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-025 tx SHALL be driven from a flop; no combinational glitch path to the pin.
REQ-026 busy = (state!=IDLE) or FIFO non-empty; fifo_full and busy combinational from registered state.

Reset
REQ-027 On reset at an edge: tx=1, state IDLE, baud/bit counters 0, FIFO empty, overrun=0, busy=0, fifo_full=0.
REQ-028 Reset mid-frame SHALL abort the frame; tx=1 after that edge; queued bytes discarded.
REQ-029 A store coinciding with reset SHALL be ignored.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
REQ-031 Macro undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, TX_ADDR=32'h80)
REQ-032 Reset then store 32'hFFFF_FF55 to 0x80 at edge N -> tx low from N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; busy low 40 cycles after N+1.
REQ-033 Six stores back-to-back 8'h01..8'h06 -> frames 01,02,03,04,05 sent contiguously (no idle between stop and start), 06 dropped, overrun=1, fifo_full seen high.
REQ-034 With overrun=1, store any value to 0x84 -> overrun=0 next cycle; store to 0x88 or memwrite=0 at 0x80 -> no FIFO or flag change.
REQ-035 Assert reset during DATA bit 3 of a frame with 2 bytes queued -> tx=1, busy=0 after the edge, no further frames.
REQ-036 UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 after bit 7, frame 44 cycles; send 8'h03 -> parity 0.
